// File: rtl/stage_id_pipe.sv
// ============================================================================
// Module   : stage_id_pipe
// Purpose  : Decode stage with registered ID/EX bundle, valid/ready handshake
//            and a load-use scoreboard that inserts bubbles on RAW hazards.
// Options  : WB_BYPASS_EN - forward same-cycle writeback into register reads
//            and clear the scoreboard combinationally for the hazard check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_id_pipe #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int MAT_LANES = 4,
  parameter int MAT_NREGS = 8,
  localparam int MAT_W    = MAT_LANES * XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      id_inst,
  input  logic [XLEN-1:0]  id_pc,
  input  logic             flush,
  input  logic [1:0]       w_select,
  input  logic [4:0]       w_regs_addr,
  input  logic [XLEN-1:0]  w_regs_data,
  input  logic [MAT_W-1:0] w_matrix_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_rs1_data,
  output logic [XLEN-1:0]  out_rs2_data,
  output logic [MAT_W-1:0] out_mat_data,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_func3,
  output logic             out_func7,
  output logic             out_br,
  output logic             out_mem_read,
  output logic             out_mem2reg,
  output logic             out_mem_write,
  output logic             out_br_addr_mode,
  output logic             out_rs2_r_select,
  output logic [2:0]       out_alu_op,
  output logic [1:0]       out_alu_src1,
  output logic [1:0]       out_alu_src2,
  output logic [1:0]       out_w_select
);

  localparam int MIDX = $clog2(MAT_NREGS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_CUST0  = 7'b0001011;

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic       br;
    logic       mem_read;
    logic       mem2reg;
    logic       mem_write;
    logic       br_addr_mode;
    logic       rs2_r_select;
    logic [2:0] alu_op;
    logic [1:0] alu_src1;
    logic [1:0] alu_src2;
    logic [1:0] w_select;
  } ctrl_t;

  state_t           state, state_next;
  ctrl_t            ctrl;
  logic [31:0]      imm32;
  logic             uses_rs1, uses_rs2;
  logic [XLEN-1:0]  regs  [NREGS];
  logic [MAT_W-1:0] mregs [MAT_NREGS];
  logic [NREGS-1:0] pend, pend_set, pend_clr, pend_chk;
  logic [XLEN-1:0]  rs1_val, rs2_val;
  logic [MAT_W-1:0] mat_val;
  logic             rs1_busy, rs2_busy, hazard, capture, load_leaves;

  wire [6:0] opcode = id_inst[6:0];
  wire [4:0] rs1    = id_inst[19:15];
  wire [4:0] rs2    = id_inst[24:20];

  assign out_valid = (state == FULL);

  // Control decode and immediate generation; also flags which sources are read.
  always_comb begin
    ctrl     = '0;
    imm32    = '0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_LUI: begin
        imm32 = {id_inst[31:12], 12'b0};
        ctrl.alu_src1 = 2'd2; ctrl.alu_src2 = 2'd1; ctrl.w_select = 2'b01;
        uses_rs1 = 1'b0;
      end
      OP_AUIPC: begin
        imm32 = {id_inst[31:12], 12'b0};
        ctrl.alu_src1 = 2'd1; ctrl.alu_src2 = 2'd1; ctrl.w_select = 2'b01;
        uses_rs1 = 1'b0;
      end
      OP_JAL: begin
        imm32 = {{11{id_inst[31]}}, id_inst[31], id_inst[19:12], id_inst[20], id_inst[30:21], 1'b0};
        ctrl.br = 1'b1; ctrl.alu_src1 = 2'd1; ctrl.alu_src2 = 2'd2; ctrl.w_select = 2'b01;
        uses_rs1 = 1'b0;
      end
      OP_JALR: begin
        imm32 = {{20{id_inst[31]}}, id_inst[31:20]};
        ctrl.br = 1'b1; ctrl.br_addr_mode = 1'b1;
        ctrl.alu_src1 = 2'd1; ctrl.alu_src2 = 2'd2; ctrl.w_select = 2'b01;
      end
      OP_BRANCH: begin
        imm32 = {{19{id_inst[31]}}, id_inst[31], id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0};
        ctrl.br = 1'b1; ctrl.alu_op = 3'd1;
        uses_rs2 = 1'b1;
      end
      OP_LOAD: begin
        imm32 = {{20{id_inst[31]}}, id_inst[31:20]};
        ctrl.mem_read = 1'b1; ctrl.mem2reg = 1'b1; ctrl.alu_src2 = 2'd1; ctrl.w_select = 2'b01;
      end
      OP_STORE: begin
        imm32 = {{20{id_inst[31]}}, id_inst[31:25], id_inst[11:7]};
        ctrl.mem_write = 1'b1; ctrl.alu_src2 = 2'd1;
        uses_rs2 = 1'b1;
      end
      OP_IMM: begin
        imm32 = {{20{id_inst[31]}}, id_inst[31:20]};
        ctrl.alu_op = 3'd2; ctrl.alu_src2 = 2'd1; ctrl.w_select = 2'b01;
      end
      OP_OP: begin
        ctrl.alu_op = 3'd3; ctrl.w_select = 2'b01;
        uses_rs2 = 1'b1;
      end
      OP_CUST0: begin
        imm32 = {{20{id_inst[31]}}, id_inst[31:20]};
        ctrl.alu_op = 3'd4; ctrl.rs2_r_select = 1'b1; ctrl.w_select = 2'b10;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  // Register file reads; x0 is hard-wired to zero and never forwarded.
  always_comb begin
    rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
    rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];
    mat_val = mregs[rs1[MIDX-1:0]];
`ifdef WB_BYPASS_EN
    if (w_select[0] && (w_regs_addr == rs1) && (rs1 != 5'd0)) rs1_val = w_regs_data;
    if (w_select[0] && (w_regs_addr == rs2) && (rs2 != 5'd0)) rs2_val = w_regs_data;
    if (w_select[1] && (w_regs_addr[MIDX-1:0] == rs1[MIDX-1:0])) mat_val = w_matrix_data;
`endif
  end

  // Scoreboard masks and load-use hazard detection.
  always_comb begin
    load_leaves = out_valid && out_ready && out_mem_read && !flush;
    pend_set = '0;
    pend_clr = '0;
    if (load_leaves && (out_rd != 5'd0)) pend_set[out_rd] = 1'b1;
    if (w_select[0]) pend_clr[w_regs_addr] = 1'b1;
`ifdef WB_BYPASS_EN
    pend_chk = pend & ~pend_clr;
`else
    pend_chk = pend;
`endif
    rs1_busy = pend_chk[rs1] || (out_valid && out_mem_read && (out_rd == rs1));
    rs2_busy = pend_chk[rs2] || (out_valid && out_mem_read && (out_rd == rs2));
    hazard   = in_valid && ((uses_rs1 && (rs1 != 5'd0) && rs1_busy) ||
                            (uses_rs2 && (rs2 != 5'd0) && rs2_busy));
  end

  // Handshake and next-state logic for the output holding register.
  always_comb begin
    in_ready   = !rst && !hazard && ((state == EMPTY) || out_ready);
    capture    = in_valid && in_ready && !flush;
    state_next = state;
    if (flush)                          state_next = EMPTY;
    else if (capture)                   state_next = FULL;
    else if (state == FULL && out_ready) state_next = EMPTY;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // Pending-load scoreboard; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~pend_clr) | pend_set;
  end

  // Scalar and matrix register file writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)     regs[i]  <= '0;
      for (int i = 0; i < MAT_NREGS; i++) mregs[i] <= '0;
    end else begin
      if (w_select[0] && (w_regs_addr != 5'd0)) regs[w_regs_addr] <= w_regs_data;
      if (w_select[1]) mregs[w_regs_addr[MIDX-1:0]] <= w_matrix_data;
    end
  end

  // ID/EX bundle: load on capture, zero when drained or flushed, else hold.
  always_ff @(posedge clk) begin
    if (rst || (!capture && (flush || out_ready || state == EMPTY))) begin
      out_pc <= '0; out_imm <= '0; out_rs1_data <= '0; out_rs2_data <= '0;
      out_mat_data <= '0; out_rd <= '0; out_rs1 <= '0; out_rs2 <= '0;
      out_func3 <= '0; out_func7 <= 1'b0; out_br <= 1'b0; out_mem_read <= 1'b0;
      out_mem2reg <= 1'b0; out_mem_write <= 1'b0; out_br_addr_mode <= 1'b0;
      out_rs2_r_select <= 1'b0; out_alu_op <= '0; out_alu_src1 <= '0;
      out_alu_src2 <= '0; out_w_select <= '0;
    end else if (capture) begin
      out_pc <= id_pc; out_imm <= XLEN'($signed(imm32));
      out_rs1_data <= rs1_val; out_rs2_data <= rs2_val; out_mat_data <= mat_val;
      out_rd <= id_inst[11:7]; out_rs1 <= rs1; out_rs2 <= rs2;
      out_func3 <= id_inst[14:12]; out_func7 <= id_inst[30];
      out_br <= ctrl.br; out_mem_read <= ctrl.mem_read; out_mem2reg <= ctrl.mem2reg;
      out_mem_write <= ctrl.mem_write; out_br_addr_mode <= ctrl.br_addr_mode;
      out_rs2_r_select <= ctrl.rs2_r_select; out_alu_op <= ctrl.alu_op;
      out_alu_src1 <= ctrl.alu_src1; out_alu_src2 <= ctrl.alu_src2;
      out_w_select <= ctrl.w_select;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stage_id_pipe.sv
// ============================================================================
// Module   : tb_stage_id_pipe
// Purpose  : Directed scoreboard bench for stage_id_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_id_pipe;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]  id_inst, id_pc, w_regs_data;
  logic [1:0]   w_select;
  logic [4:0]   w_regs_addr;
  logic [127:0] w_matrix_data;
  logic [31:0]  out_pc, out_imm, out_rs1_data, out_rs2_data;
  logic [127:0] out_mat_data;
  logic [4:0]   out_rd, out_rs1, out_rs2;
  logic [2:0]   out_func3, out_alu_op;
  logic         out_func7, out_br, out_mem_read, out_mem2reg, out_mem_write;
  logic         out_br_addr_mode, out_rs2_r_select;
  logic [1:0]   out_alu_src1, out_alu_src2, out_w_select;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0]  pc, imm, r1, r2;
    logic [4:0]   rd;
    logic [127:0] mat;
    logic         mr;
    logic [1:0]   ws;
  } exp_t;
  exp_t q[$];

  localparam logic [127:0] MAT_VAL = {32'h44, 32'h33, 32'h22, 32'h11};

  stage_id_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .id_inst(id_inst), .id_pc(id_pc), .flush(flush), .w_select(w_select),
    .w_regs_addr(w_regs_addr), .w_regs_data(w_regs_data), .w_matrix_data(w_matrix_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_mat_data(out_mat_data),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_func3(out_func3),
    .out_func7(out_func7), .out_br(out_br), .out_mem_read(out_mem_read),
    .out_mem2reg(out_mem2reg), .out_mem_write(out_mem_write),
    .out_br_addr_mode(out_br_addr_mode), .out_rs2_r_select(out_rs2_r_select),
    .out_alu_op(out_alu_op), .out_alu_src1(out_alu_src1), .out_alu_src2(out_alu_src2),
    .out_w_select(out_w_select)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd,
                      input logic [31:0] r1, input logic [31:0] r2, input logic [127:0] mat,
                      input logic mr, input logic [1:0] ws);
    exp_t e;
    e.pc = pc; e.imm = imm; e.rd = rd; e.r1 = r1; e.r2 = r2; e.mat = mat; e.mr = mr; e.ws = ws;
    q.push_back(e);
  endtask

  // Pop an expected bundle each time EX accepts one and compare the fields.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("sb_expected_present", 128'(q.size() > 0), 128'(1));
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sb_pc",       out_pc,       e.pc);
        chk("sb_imm",      out_imm,      e.imm);
        chk("sb_rd",       out_rd,       e.rd);
        chk("sb_rs1_data", out_rs1_data, e.r1);
        chk("sb_rs2_data", out_rs2_data, e.r2);
        chk("sb_mat_data", out_mat_data, e.mat);
        chk("sb_mem_read", out_mem_read, e.mr);
        chk("sb_w_select", out_w_select, e.ws);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; id_inst = '0; id_pc = '0; flush = 1'b0;
    w_select = '0; w_regs_addr = '0; w_regs_data = '0; w_matrix_data = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_mem_read", out_mem_read, 0);
    chk("rst_out_rs1_data", out_rs1_data, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0; #1;
    chk("release_in_ready", in_ready, 1);

    // addi x1,x0,5
    id_inst = 32'h00500093; id_pc = 32'h100; in_valid = 1'b1; #1;
    chk("addi_in_ready", in_ready, 1);
    push(32'h100, 32'd5, 5'd1, 32'd0, 32'd0, '0, 1'b0, 2'b01);
    step(); in_valid = 1'b0;
    chk("addi_out_valid", out_valid, 1);
    chk("addi_alu_op", out_alu_op, 3'd2);
    chk("addi_alu_src2", out_alu_src2, 2'd1);
    step();

    // lw x2,0(x1) followed by add x3,x2,x2
    id_inst = 32'h0000A103; id_pc = 32'h104; in_valid = 1'b1; #1;
    chk("lw_in_ready", in_ready, 1);
    push(32'h104, 32'd0, 5'd2, 32'd0, 32'd0, '0, 1'b1, 2'b01);
    step();
    id_inst = 32'h002101B3; id_pc = 32'h108; #1;
    chk("add_stall_inflight", in_ready, 0);
    step();
    chk("bubble_out_valid", out_valid, 0);
    chk("bubble_mem_read", out_mem_read, 0);
    chk("add_stall_pend", in_ready, 0);
    step();
    chk("add_stall_pend2", in_ready, 0);
    w_select = 2'b01; w_regs_addr = 5'd2; w_regs_data = 32'hDEADBEEF; #1;
`ifdef WB_BYPASS_EN
    chk("wb_same_cycle_ready", in_ready, 1);
    push(32'h108, 32'd0, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, '0, 1'b0, 2'b01);
    step(); w_select = 2'b00;
`else
    chk("wb_same_cycle_stall", in_ready, 0);
    step(); w_select = 2'b00; #1;
    chk("wb_next_cycle_ready", in_ready, 1);
    push(32'h108, 32'd0, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, '0, 1'b0, 2'b01);
    step();
`endif
    in_valid = 1'b0;
    chk("add_out_valid", out_valid, 1);
    step();

    // back-pressure hold for three cycles
    out_ready = 1'b0;
    id_inst = 32'h00710213; id_pc = 32'h10C; in_valid = 1'b1; #1;
    chk("hold_capture_ready", in_ready, 1);
    push(32'h10C, 32'd7, 5'd4, 32'hDEADBEEF, 32'd0, '0, 1'b0, 2'b01);
    step();
    id_inst = 32'hFFF00293; id_pc = 32'h110;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_pc", out_pc, 32'h10C);
      chk("hold_out_rs1_data", out_rs1_data, 32'hDEADBEEF);
      step();
    end
    out_ready = 1'b1; #1;
    chk("release_in_ready_full", in_ready, 1);
    push(32'h110, 32'hFFFFFFFF, 5'd5, 32'd0, 32'd0, '0, 1'b0, 2'b01);
    step(); in_valid = 1'b0;
    chk("next_bundle_pc", out_pc, 32'h110);
    step();

    // matrix write then custom-0 read at rs1=3
    w_select = 2'b10; w_regs_addr = 5'd3; w_matrix_data = MAT_VAL;
    step(); w_select = 2'b00;
    id_inst = 32'h0001830B; id_pc = 32'h114; in_valid = 1'b1; #1;
    chk("mat_in_ready", in_ready, 1);
    push(32'h114, 32'd0, 5'd6, 32'd0, 32'd0, MAT_VAL, 1'b0, 2'b10);
    step(); in_valid = 1'b0;
    step();

    // flush a held load; its rd must not become pending
    out_ready = 1'b0;
    id_inst = 32'h00002383; id_pc = 32'h118; in_valid = 1'b1; #1;
    chk("flush_capture_ready", in_ready, 1);
    step(); in_valid = 1'b0;
    chk("flush_pre_valid", out_valid, 1);
    chk("flush_pre_mem_read", out_mem_read, 1);
    flush = 1'b1;
    step(); flush = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    id_inst = 32'h00738433; id_pc = 32'h11C; in_valid = 1'b1; #1;
    chk("flush_no_pend", in_ready, 1);
    push(32'h11C, 32'd0, 5'd8, 32'd0, 32'd0, '0, 1'b0, 2'b01);
    step(); in_valid = 1'b0;
    step();

    // write to x0 concurrent with a read of x0
    w_select = 2'b01; w_regs_addr = 5'd0; w_regs_data = 32'h12345678;
    id_inst = 32'h000004B3; id_pc = 32'h120; in_valid = 1'b1; #1;
    chk("x0_in_ready", in_ready, 1);
    push(32'h120, 32'd0, 5'd9, 32'd0, 32'd0, '0, 1'b0, 2'b01);
    step(); w_select = 2'b00; in_valid = 1'b0;
    step(); step();

    chk("queue_drained", 128'(q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
